spi_transmit: RTL and testbench

SPI peripheral-side transmitter that returns processed data (e.g. edge-detection result bytes) from the FPGA to the MCU over `sdo`. It is the transmit counterpart of the SPI receive path: the same `cs` framing (active-high), MSB-first, with the MCU sampling `sdo` on falling `sck`. The block runs entirely in the system clock domain. It oversamples the external `sck`/`cs` through synchronizers and feeds the shift register from a small internal FIFO written by the datapath.

---
 rtl/spi_transmit_if.sv | 28 ++
 rtl/spi_transmit.sv | 165 ++++++++++++++++
 tb/tb_spi_transmit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/spi_transmit_if.sv
// Groups the SPI transmit signals: the enqueue handshake from the datapath, the SPI pins, and the status outputs.
// Latency: none; this file only bundles signals.
// Backpressure: while txReady is low, the producer holds txValid and txData.
interface spi_transmit_if #(
  parameter int messageBits = 8
);
  logic [messageBits-1:0] txData;
  logic                   txValid;
  logic                   txReady;
  logic                   sck;
  logic                   cs;
  logic                   sdo;
  logic                   wordDone;
  logic                   busy;
  logic                   underrun;

  // Transmitter side
  modport slave (
    input  txData, txValid, sck, cs,
    output txReady, sdo, wordDone, busy, underrun
  );

  // Datapath and MCU side
  modport master (
    output txData, txValid, sck, cs,
    input  txReady, sdo, wordDone, busy, underrun
  );
endinterface

// File: rtl/spi_transmit.sv
// SPI peripheral transmitter: shifts out words from a small FIFO on sdo, MSB first, framed by an active-high cs.
// Latency: an sck/cs pin edge is acted on at the 3rd clk rising edge after it; sdo is registered.
// Backpressure: txReady = !full. When the FIFO is empty at a word load, fillWord is sent and underrun is set.

// Generic synchronous FIFO. The caller must not push when full or pop when empty.
module fifo_sync #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] dat_i,
  input  logic         pop_i,
  output logic [W-1:0] dat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  assign dat_o   = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));

  // Storage has no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= dat_i;
  end

  // Read/write pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module spi_transmit #(
  parameter int                     messageBits = 8,
  parameter int                     fifoDepth   = 4,
  parameter logic [messageBits-1:0] fillWord    = '0
) (
  input logic            clk,
  input logic            rst,
  spi_transmit_if.slave  bus
);
  localparam int KW = $clog2(messageBits + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q;
  logic [2:0]             sck_q, cs_q;    // [0],[1] synchronizer, [2] edge-detect delay
  logic [messageBits-1:0] shift_q;
  logic [KW-1:0]          k_q;
  logic                   sdo_q, word_done_q, busy_q, underrun_q;

  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic                   push, pop, load, fifo_empty, fifo_full;
  logic [messageBits-1:0] head, word_d, shifted;
  logic [KW-1:0]          k_d;

  assign sck_rise =  sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] &  sck_q[2];
  assign cs_rise  =  cs_q[1]  & ~cs_q[2];
  assign cs_fall  = ~cs_q[1]  &  cs_q[2];

  // Bring the asynchronous SPI pins into the clk domain and keep one extra delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q <= '0;
      cs_q  <= '0;
    end else begin
      sck_q <= {sck_q[1:0], bus.sck};
      cs_q  <= {cs_q[1:0], bus.cs};
    end
  end

  assign push        = bus.txValid & ~fifo_full;
  assign bus.txReady = ~fifo_full;

  fifo_sync #(.W(messageBits), .DEPTH(fifoDepth)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .dat_i   (bus.txData),
    .pop_i   (pop),
    .dat_o   (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign k_d     = k_q + KW'(1);
  assign shifted = shift_q << 1;
  // A word is loaded when a frame opens, or when the last bit of a word has been sampled. A cs fall cancels either load.
  assign load    = ~cs_fall &
                   (((state_q == IDLE) && cs_rise) ||
                    ((state_q == SHIFT) && sck_fall && (k_d == KW'(messageBits))));
  assign pop     = load & ~fifo_empty;
  assign word_d  = fifo_empty ? fillWord : head;

  // Frame FSM. All outputs are registered. A cs fall overrides any coincident sck edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      k_q         <= '0;
      sdo_q       <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      word_done_q <= 1'b0;
      if (cs_fall) begin
        state_q <= IDLE;
        sdo_q   <= 1'b0;
        k_q     <= '0;
        busy_q  <= 1'b0;
      end else if (state_q == IDLE) begin
        if (cs_rise) begin
          state_q    <= SHIFT;
          busy_q     <= 1'b1;
          shift_q    <= word_d;
          sdo_q      <= word_d[messageBits-1];
          k_q        <= '0;
          underrun_q <= fifo_empty;      // clear the sticky flag, unless this load also underruns
        end
      end else begin
        if (sck_rise && (k_q != '0)) begin
          // The MSB stays on sdo through the first rising edge; later rising edges present the next bit.
          shift_q <= shifted;
          sdo_q   <= shifted[messageBits-1];
        end else if (sck_fall) begin
          if (load) begin
            word_done_q <= 1'b1;
            shift_q     <= word_d;
            sdo_q       <= word_d[messageBits-1];
            k_q         <= '0;
            if (fifo_empty) underrun_q <= 1'b1;
          end else begin
            k_q <= k_d;
          end
        end
      end
    end
  end

  assign bus.sdo      = sdo_q;
  assign bus.wordDone = word_done_q;
  assign bus.busy     = busy_q;
  assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_spi_transmit.sv
// Bench for spi_transmit: table-driven frames plus hand-written abort, idle-sck and async-reset sequences.
// Latency: sck half-period is 8 clk; the MCU samples sdo just before it drives sck low.
// Backpressure: the full-FIFO vector pushes a 5th word while txReady is low and expects it to be dropped.
module tb_spi_transmit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_transmit_if #(.messageBits(8)) bus ();

  spi_transmit #(.messageBits(8), .fifoDepth(4), .fillWord(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wd_cnt   = 0;

  // Count wordDone pulses, sampling away from the active edge.
  always @(negedge clk) if (bus.wordDone === 1'b1) wd_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] w);
    bus.txData  = w;
    bus.txValid = 1'b1;
    @(negedge clk);
    bus.txValid = 1'b0;
  endtask

  // Clock nbits sck cycles. Each bit is sampled just before sck falls.
  task automatic run_bits(input int nbits, output logic [31:0] data, output logic und_last);
    data     = '0;
    und_last = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      bus.sck = 1'b1;
      waitclk(8);
      data     = {data[30:0], bus.sdo};
      und_last = bus.underrun;
      bus.sck  = 1'b0;
      waitclk(8);
    end
  endtask

  typedef struct {
    int               n_push;
    logic [3:0][7:0]  w;          // byte j is the j-th word pushed
    int               nbits;
    logic [31:0]      exp_data;
    int               exp_wd;
    logic             exp_und_last;  // underrun at the last sample, before the end-of-word load
    logic             exp_und_end;   // underrun after cs falls
  } vec_t;

  vec_t        vt [4];
  logic [31:0] data;
  logic        und_last;
  int          wd0;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.sck = 1'b0; bus.cs = 1'b0; bus.txValid = 1'b0; bus.txData = '0;

    // Each frame ends with a word load. When the FIFO is empty at that load, underrun ends high.
    vt[0] = '{1, 32'h000000A5,  8, 32'h000000A5, 1, 1'b0, 1'b1};
    vt[1] = '{2, 32'h0000FF3C, 16, 32'h00003CFF, 2, 1'b0, 1'b1};
    vt[2] = '{1, 32'h00000081, 16, 32'h00008100, 2, 1'b1, 1'b1};
    vt[3] = '{4, 32'h44332211, 32, 32'h11223344, 4, 1'b0, 1'b1};

    // Check the reset values.
    waitclk(2);
    check("rst_sdo",      32'(bus.sdo),      32'd0);
    check("rst_txReady",  32'(bus.txReady),  32'd1);
    check("rst_wordDone", 32'(bus.wordDone), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_underrun", 32'(bus.underrun), 32'd0);
    rst = 1'b0;
    waitclk(3);

    // sck toggling while cs is low must not change the outputs.
    wd0 = wd_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.sck = 1'b1; waitclk(4); bus.sck = 1'b0; waitclk(4);
    end
    check("idle_sck_sdo",  32'(bus.sdo),  32'd0);
    check("idle_sck_busy", 32'(bus.busy), 32'd0);
    check("idle_sck_wd",   32'(wd_cnt - wd0), 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < vt[i].n_push; j++) push_word(vt[i].w[j]);
      if (vt[i].n_push == 4) begin
        check("full_txReady", 32'(bus.txReady), 32'd0);
        push_word(8'h55);
      end
      wd0    = wd_cnt;
      bus.cs = 1'b1;
      waitclk(6);
      check("frame_busy", 32'(bus.busy), 32'd1);
      run_bits(vt[i].nbits, data, und_last);
      bus.cs = 1'b0;
      waitclk(6);
      check("frame_data",     data,                    vt[i].exp_data);
      check("frame_wordDone", 32'(wd_cnt - wd0),       32'(vt[i].exp_wd));
      check("frame_und_last", 32'(und_last),           32'(vt[i].exp_und_last));
      check("frame_und_end",  32'(bus.underrun),       32'(vt[i].exp_und_end));
      check("frame_sdo_idle", 32'(bus.sdo),            32'd0);
      check("frame_busy_end", 32'(bus.busy),           32'd0);
    end

    // Abort: drop cs after 4 bits of 0xF0; the partial word is lost and 0x0F comes next.
    push_word(8'hF0);
    push_word(8'h0F);
    wd0    = wd_cnt;
    bus.cs = 1'b1;
    waitclk(6);
    run_bits(4, data, und_last);
    bus.cs = 1'b0;
    waitclk(6);
    check("abort_bits",     data,               32'h0000000F);
    check("abort_wordDone", 32'(wd_cnt - wd0),  32'd0);
    check("abort_sdo",      32'(bus.sdo),       32'd0);
    check("abort_busy",     32'(bus.busy),      32'd0);
    check("abort_underrun", 32'(bus.underrun),  32'd0);
    wd0    = wd_cnt;
    bus.cs = 1'b1;
    waitclk(6);
    run_bits(8, data, und_last);
    bus.cs = 1'b0;
    waitclk(6);
    check("after_abort_data", data,              32'h0000000F);
    check("after_abort_wd",   32'(wd_cnt - wd0), 32'd1);

    // Async reset mid-frame, asserted between clk edges.
    push_word(8'hAA); push_word(8'hBB); push_word(8'hCC); push_word(8'hDD);
    bus.cs = 1'b1;
    waitclk(6);
    push_word(8'hEE);
    check("pre_rst_busy",    32'(bus.busy),    32'd1);
    check("pre_rst_sdo",     32'(bus.sdo),     32'd1);
    check("pre_rst_txReady", 32'(bus.txReady), 32'd0);
    #2;
    rst    = 1'b1;
    bus.cs = 1'b0;
    #1;
    check("arst_sdo",      32'(bus.sdo),      32'd0);
    check("arst_busy",     32'(bus.busy),     32'd0);
    check("arst_txReady",  32'(bus.txReady),  32'd1);
    check("arst_underrun", 32'(bus.underrun), 32'd0);
    check("arst_wordDone", 32'(bus.wordDone), 32'd0);
    waitclk(2);
    rst = 1'b0;
    waitclk(3);
    push_word(8'h5A);
    wd0    = wd_cnt;
    bus.cs = 1'b1;
    waitclk(6);
    run_bits(8, data, und_last);
    bus.cs = 1'b0;
    waitclk(6);
    check("post_rst_data", data,              32'h0000005A);
    check("post_rst_wd",   32'(wd_cnt - wd0), 32'd1);
    check("post_rst_und",  32'(und_last),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
